// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard detector for the ID stage.
// A load whose result is still unavailable is tracked for LOAD_LAT cycles
// after it leaves EX: first in EX itself, then in LOAD_LAT-1 pending slots.
// Any dependent reader in ID is held until the load's data is forwardable.
// Define HAZARD_STATS_EN to build the saturating stall-cycle counter;
// without it StallCnt_o is tied to zero and no counter flops exist.
module load_use_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] IFID_RS1_i,
    input  logic [REG_AW-1:0] IFID_RS2_i,
    input  logic              IFID_RS1Used_i,
    input  logic              IFID_RS2Used_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_RD_i,
    input  logic              MemStall_i,
    output logic              PCWrite_o,
    output logic              Stall_o,
    output logic              NoOp_o,
    output logic [CNT_W-1:0]  StallCnt_o
);

    logic slot_hit_rs1;
    logic slot_hit_rs2;
    logic match_rs1;
    logic match_rs2;
    logic hazard;

    if (LOAD_LAT > 1) begin : g_slots
        localparam int NSLOT = LOAD_LAT - 1;

        // Slot 0 is the youngest pending load; higher indices are older.
        logic [NSLOT-1:0]             slot_vld_d, slot_vld_q;
        logic [NSLOT-1:0][REG_AW-1:0] slot_rd_d, slot_rd_q;

        // Shift the load leaving EX into the slots; freeze on a memory stall.
        always_comb begin
            slot_vld_d = slot_vld_q;
            slot_rd_d  = slot_rd_q;
            if (!MemStall_i) begin
                slot_vld_d[0] = IDEX_MemRead_i && (IDEX_RD_i != '0);
                slot_rd_d[0]  = IDEX_RD_i;
                for (int k = 1; k < NSLOT; k++) begin
                    slot_vld_d[k] = slot_vld_q[k-1];
                    slot_rd_d[k]  = slot_rd_q[k-1];
                end
            end
        end

        // Slot registers, cleared asynchronously.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                slot_vld_q <= '0;
                slot_rd_q  <= '0;
            end else begin
                slot_vld_q <= slot_vld_d;
                slot_rd_q  <= slot_rd_d;
            end
        end

        // Compare both ID sources against every valid pending slot.
        always_comb begin
            slot_hit_rs1 = 1'b0;
            slot_hit_rs2 = 1'b0;
            for (int k = 0; k < NSLOT; k++) begin
                if (slot_vld_q[k] && (slot_rd_q[k] == IFID_RS1_i)) slot_hit_rs1 = 1'b1;
                if (slot_vld_q[k] && (slot_rd_q[k] == IFID_RS2_i)) slot_hit_rs2 = 1'b1;
            end
        end
    end else begin : g_no_slots
        // Single-cycle latency: only the load currently in EX can conflict.
        assign slot_hit_rs1 = 1'b0;
        assign slot_hit_rs2 = 1'b0;
    end

    // Hazard detection and output priority: memory freeze beats load-use bubble.
    always_comb begin
        match_rs1 = IFID_RS1Used_i && (IFID_RS1_i != '0) &&
                    ((IDEX_MemRead_i && (IDEX_RD_i == IFID_RS1_i)) || slot_hit_rs1);
        match_rs2 = IFID_RS2Used_i && (IFID_RS2_i != '0) &&
                    ((IDEX_MemRead_i && (IDEX_RD_i == IFID_RS2_i)) || slot_hit_rs2);
        hazard    = match_rs1 || match_rs2;
        PCWrite_o = 1'b0;
        Stall_o   = 1'b0;
        NoOp_o    = 1'b0;
        // Outputs are forced low for the whole time reset is asserted.
        if (rst_i) begin
            if (MemStall_i) begin
                PCWrite_o = 1'b1;
                Stall_o   = 1'b1;
            end else if (hazard) begin
                PCWrite_o = 1'b1;
                Stall_o   = 1'b1;
                NoOp_o    = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             count_en;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Count bubble-inserting cycles only, saturating at all-ones.
    always_comb begin
        count_en    = hazard && !MemStall_i;
        stall_cnt_d = stall_cnt_q;
        if (count_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
`else
    assign StallCnt_o = '0;
`endif

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use hazard detector in the 5-stage pipeline. Sits beside the ID stage.
- Tracks loads whose data is not yet forwardable for LOAD_LAT cycles after leaving EX, so multi-cycle data memories stall correctly.
- Honours per-source "register used" qualifiers, ignores x0, and freezes without bubbling during a data-memory stall.
- Optionally counts stall cycles for performance analysis.

Parameters:
- REG_AW, 5, register address width (2^REG_AW architectural registers).
- LOAD_LAT, 2, cycles from load in EX until its result is forwardable; legal range 1..4. A value of 1 gives classic single-bubble load-use behaviour.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- IFID_RS1_i  in  REG_AW  rs1 of instruction in ID.
- IFID_RS2_i  in  REG_AW  rs2 of instruction in ID.
- IFID_RS1Used_i  in  1  instruction in ID reads rs1.
- IFID_RS2Used_i  in  1  instruction in ID reads rs2.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RD_i  in  REG_AW  destination of instruction in EX.
- MemStall_i  in  1  data memory busy; the whole pipeline must freeze.
- PCWrite_o  out  1  high = hold PC (existing pipeline polarity).
- Stall_o  out  1  high = hold IF/ID register.
- NoOp_o  out  1  high = inject bubble into ID/EX.
- StallCnt_o  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: while rst_i low, all pending slots are invalid, StallCnt_o = 0, and PCWrite_o / Stall_o / NoOp_o are forced to 0. Reset is asynchronous; release is sampled on clk_i.
- Pending slots: LOAD_LAT-1 entries, each holding {valid, rd}; slot[0] is youngest. None exist when LOAD_LAT = 1.
- Slot update each rising edge when MemStall_i = 0:
  - slot[0] <= {IDEX_MemRead_i && IDEX_RD_i != 0, IDEX_RD_i}
  - slot[k] <= slot[k-1]; the oldest entry is discarded.
- Slot update when MemStall_i = 1: all slots hold.
- Match function for source s: used_s && s != 0 && (
  - (IDEX_MemRead_i && IDEX_RD_i == s), or
  - any slot[k].valid && slot[k].rd == s ).
- hazard = match(RS1) || match(RS2). Combinational, same cycle as the inputs (zero latency).
- Output priority:
  1. MemStall_i = 1: PCWrite_o = 1, Stall_o = 1, NoOp_o = 0 (freeze, no bubble), whatever the hazard value.
  2. Else if hazard: PCWrite_o = 1, Stall_o = 1, NoOp_o = 1.
  3. Else: all 0.
- Consequence: a dependent instruction following a load directly stalls LOAD_LAT cycles. A dependent instruction separated by one unrelated instruction stalls LOAD_LAT-1 cycles.
- Because a bubble enters EX during a stall, slot[0] receives invalid in the next cycle. No double-counting occurs.
- Both sources matching different pending loads: a single stall per cycle. The stall persists until neither match remains.
- rd = x0 loads never create a hazard and never occupy a valid slot.
- Counter: increments by 1 on each edge where case 2 applies (hazard && !MemStall_i). It saturates at 2^CNT_W-1 and does not wrap. Memory-freeze cycles are not counted.

Optional Feature:
- HAZARD_STATS_EN defined: StallCnt_o behaves as above.
- HAZARD_STATS_EN undefined: no counter flops are built and StallCnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- LOAD_LAT=1, EX=lw x5, ID rs1=x5 used -> one cycle of PCWrite_o/Stall_o/NoOp_o=1. Next cycle all 0 (slots absent). StallCnt_o=1.
- LOAD_LAT=2, lw x5 then dependent add x6,x5,x7 back-to-back -> outputs high 2 consecutive cycles, then 0. StallCnt_o=2. With one independent instruction between them -> 1 stall cycle.
- lw x0 followed by rs1=x0 used; also lw x5 followed by rs2=x5 with IFID_RS2Used_i=0 -> no stall in either case.
- LOAD_LAT=2, hazard pending, MemStall_i=1 for 3 cycles -> PCWrite_o=1, Stall_o=1, NoOp_o=0; slots and StallCnt_o unchanged. After MemStall_i drops, the remaining stall cycle occurs with NoOp_o=1.
- CNT_W=4, continuous hazard for 20 cycles -> StallCnt_o reaches 15 and holds. Assert rst_i low mid-stall -> outputs 0 immediately, counter 0, slots cleared, and no stall after release.
- Build without HAZARD_STATS_EN, repeat the first scenario -> identical stall outputs, StallCnt_o=0 throughout.
